// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
// Constants shared by the ROB stage and the reorder-buffer storage:
// exception-type encoding, register/data widths and the default ROB size.
package reorder_buffer_pkg;

    // Exception-type field; EXC_TYPE_NULL means "no exception".
    localparam int EXC_TYPE_WIDTH = 4;
    localparam logic [EXC_TYPE_WIDTH-1:0] EXC_TYPE_NULL = '0;

    // Architectural widths.
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int PC_WIDTH       = 32;

    // Default entry-id width (DEPTH = 2**ROB_ADDR_WIDTH).
    localparam int ROB_ADDR_WIDTH = 4;

endpackage

// File: rtl/reorder_buffer_ptr_ctrl.sv
// rob_ptr_ctrl
// Head/tail/occupancy bookkeeping for the circular reorder buffer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous clear of all pointers (highest priority)
//   alloc         an entry is allocated at tail this cycle
//   retire        the head entry is retired this cycle
//   head, tail    entry ids, wrap modulo DEPTH
//   count         occupancy 0..DEPTH
//   full, empty   derived from count
module rob_ptr_ctrl
    import reorder_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ROB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic                  retire,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Pointers wrap naturally through their ADDR_WIDTH-bit width.
            if (alloc)  tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            case ({alloc, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
// Circular reorder-buffer storage behind the ROB stage. Allocates entries in
// order (the id doubles as the rename ref id), accepts out-of-order result
// write-backs, and presents the oldest entry for commit.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush                        discard all entries (next cycle empty)
//   write_en / can_write         allocate at tail / not full
//   write_addr                   id the next allocation receives
//   write_*                      fields captured on allocation
//   wb_en, wb_id, wb_data,
//   wb_exception_type            execute write-back into a valid entry
//   commit_en / can_commit       retire head / head valid and done
//   commit_*                     head entry fields (zero when empty)
//   count                        occupancy 0..DEPTH
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
    parameter int EXC_WIDTH  = EXC_TYPE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    // allocation channel
    input  logic                      write_en,
    output logic                      can_write,
    output logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic                      write_reg_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_write_addr,
    input  logic [EXC_WIDTH-1:0]      write_exception_type,
    input  logic                      write_is_delayslot,
    input  logic [PC_WIDTH-1:0]       write_pc,
    // write-back channel
    input  logic                      wb_en,
    input  logic [ADDR_WIDTH-1:0]     wb_id,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [EXC_WIDTH-1:0]      wb_exception_type,
    // commit channel
    input  logic                      commit_en,
    output logic                      can_commit,
    output logic                      commit_reg_write_en,
    output logic [REG_ADDR_WIDTH-1:0] commit_reg_write_addr,
    output logic [DATA_WIDTH-1:0]     commit_reg_write_data,
    output logic [EXC_WIDTH-1:0]      commit_exception_type,
    output logic                      commit_is_delayslot,
    output logic [PC_WIDTH-1:0]       commit_pc,
    output logic [ADDR_WIDTH:0]       count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [EXC_WIDTH-1:0] EXC_NULL = EXC_WIDTH'(EXC_TYPE_NULL);

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  full;
    logic                  empty;
    logic                  alloc;
    logic                  retire;
    logic                  wb_fire;

    // Per-entry status bits.
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;

    // Per-entry payload.
    logic                      reg_we_q  [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] reg_addr_q[DEPTH];
    logic [DATA_WIDTH-1:0]     data_q    [DEPTH];
    logic [EXC_WIDTH-1:0]      exc_q     [DEPTH];
    logic                      ds_q      [DEPTH];
    logic [PC_WIDTH-1:0]       pc_q      [DEPTH];

    rob_ptr_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ptr_ctrl (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .alloc (alloc),
        .retire(retire),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign can_write  = !full;
    assign can_commit = !empty && valid_q[head] && done_q[head];
    assign write_addr = tail;

    assign alloc  = write_en && can_write;
    assign retire = commit_en && can_commit;

    // A write-back only lands in an entry valid before the edge; one aimed at
    // the head being retired this cycle is dropped. The slot being allocated
    // is never valid pre-edge, so alloc and wb never hit the same entry.
    assign wb_fire = wb_en && valid_q[wb_id] && !(retire && (wb_id == head));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (wb_fire) begin
                done_q[wb_id] <= 1'b1;
            end
            if (retire) begin
                valid_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
            end
            if (alloc) begin
                valid_q[tail] <= 1'b1;
                // A decode-time exception needs no result before commit.
                done_q[tail]  <= (write_exception_type != EXC_NULL);
            end
        end
    end

    // NOTE: the payload array carries no reset; an entry is only observed
    // after it has been allocated, and the commit fields are forced to zero
    // while the buffer is empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (alloc) begin
                reg_we_q[tail]   <= write_reg_write_en;
                reg_addr_q[tail] <= write_reg_write_addr;
                data_q[tail]     <= '0;
                exc_q[tail]      <= write_exception_type;
                ds_q[tail]       <= write_is_delayslot;
                pc_q[tail]       <= write_pc;
            end
            if (wb_fire) begin
                data_q[wb_id] <= wb_data;
                // Execute-time exceptions override; NULL keeps the decode one.
                if (wb_exception_type != EXC_NULL) begin
                    exc_q[wb_id] <= wb_exception_type;
                end
            end
        end
    end

    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        commit_reg_write_en   = 1'b0;
        commit_reg_write_addr = '0;
        commit_reg_write_data = '0;
        commit_exception_type = '0;
        commit_is_delayslot   = 1'b0;
        commit_pc             = '0;
        if (!empty) begin
            commit_reg_write_en   = reg_we_q[head];
            commit_reg_write_addr = reg_addr_q[head];
            commit_reg_write_data = data_q[head];
            commit_exception_type = exc_q[head];
            commit_is_delayslot   = ds_q[head];
            commit_pc             = pc_q[head];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
// Self-checking bench: a queue-based model of the buffer is stepped on every
// rising edge and compared with the DUT on every falling edge; directed
// sequences add literal expectations, then a randomized phase follows.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int AW    = ROB_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = EXC_TYPE_WIDTH;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            write_en;
    logic            can_write;
    logic [AW-1:0]   write_addr;
    logic            write_reg_write_en;
    logic [4:0]      write_reg_write_addr;
    logic [EW-1:0]   write_exception_type;
    logic            write_is_delayslot;
    logic [31:0]     write_pc;
    logic            wb_en;
    logic [AW-1:0]   wb_id;
    logic [31:0]     wb_data;
    logic [EW-1:0]   wb_exception_type;
    logic            commit_en;
    logic            can_commit;
    logic            commit_reg_write_en;
    logic [4:0]      commit_reg_write_addr;
    logic [31:0]     commit_reg_write_data;
    logic [EW-1:0]   commit_exception_type;
    logic            commit_is_delayslot;
    logic [31:0]     commit_pc;
    logic [AW:0]     count;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer #(
        .ADDR_WIDTH(AW),
        .EXC_WIDTH (EW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .write_en             (write_en),
        .can_write            (can_write),
        .write_addr           (write_addr),
        .write_reg_write_en   (write_reg_write_en),
        .write_reg_write_addr (write_reg_write_addr),
        .write_exception_type (write_exception_type),
        .write_is_delayslot   (write_is_delayslot),
        .write_pc             (write_pc),
        .wb_en                (wb_en),
        .wb_id                (wb_id),
        .wb_data              (wb_data),
        .wb_exception_type    (wb_exception_type),
        .commit_en            (commit_en),
        .can_commit           (can_commit),
        .commit_reg_write_en  (commit_reg_write_en),
        .commit_reg_write_addr(commit_reg_write_addr),
        .commit_reg_write_data(commit_reg_write_data),
        .commit_exception_type(commit_exception_type),
        .commit_is_delayslot  (commit_is_delayslot),
        .commit_pc            (commit_pc),
        .count                (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          valid;
        bit          done;
        bit          rwe;
        bit [4:0]    raddr;
        bit [31:0]   data;
        bit [EW-1:0] exc;
        bit          ds;
        bit [31:0]   pc;
    } m_ent_t;

    m_ent_t m_ent[DEPTH];
    int     m_q[$];     // live ids, oldest first
    int     m_next;     // id handed to the next allocation

    function automatic void model_reset();
        m_q.delete();
        m_next = 0;
        for (int i = 0; i < DEPTH; i++) m_ent[i] = '{default: 0};
    endfunction

    function automatic bit m_can_commit();
        return (m_q.size() > 0) && m_ent[m_q[0]].done;
    endfunction

    function automatic void model_step();
        bit do_alloc;
        bit do_commit;
        int h;
        if (flush) begin
            model_reset();
            return;
        end
        do_alloc  = write_en && (m_q.size() < DEPTH);
        do_commit = commit_en && m_can_commit();
        h = (m_q.size() > 0) ? m_q[0] : -1;
        if (wb_en && m_ent[wb_id].valid && !(do_commit && int'(wb_id) == h)) begin
            m_ent[wb_id].data = wb_data;
            m_ent[wb_id].done = 1'b1;
            if (wb_exception_type != EXC_TYPE_NULL) m_ent[wb_id].exc = wb_exception_type;
        end
        if (do_commit) begin
            m_ent[h] = '{default: 0};
            void'(m_q.pop_front());
        end
        if (do_alloc) begin
            m_ent[m_next] = '{valid: 1'b1,
                              done:  (write_exception_type != EXC_TYPE_NULL),
                              rwe:   write_reg_write_en,
                              raddr: write_reg_write_addr,
                              data:  32'h0,
                              exc:   write_exception_type,
                              ds:    write_is_delayslot,
                              pc:    write_pc};
            m_q.push_back(m_next);
            m_next = (m_next + 1) % DEPTH;
        end
    endfunction

    always @(posedge clk) if (!rst) model_step();
    always @(posedge rst) model_reset();

    task automatic compare_model();
        m_ent_t e;
        e = '{default: 0};
        if (m_q.size() > 0) e = m_ent[m_q[0]];
        check("m_count",      64'(count),                 64'(m_q.size()));
        check("m_can_write",  64'(can_write),             64'(m_q.size() < DEPTH));
        check("m_write_addr", 64'(write_addr),            64'(m_next));
        check("m_can_commit", 64'(can_commit),            64'(m_can_commit()));
        check("m_c_rwe",      64'(commit_reg_write_en),   64'(e.rwe));
        check("m_c_raddr",    64'(commit_reg_write_addr), 64'(e.raddr));
        check("m_c_data",     64'(commit_reg_write_data), 64'(e.data));
        check("m_c_exc",      64'(commit_exception_type), 64'(e.exc));
        check("m_c_ds",       64'(commit_is_delayslot),   64'(e.ds));
        check("m_c_pc",       64'(commit_pc),             64'(e.pc));
    endtask

    always @(negedge clk) compare_model();

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush = 0; write_en = 0; write_reg_write_en = 0; write_reg_write_addr = '0;
        write_exception_type = EXC_TYPE_NULL; write_is_delayslot = 0; write_pc = '0;
        wb_en = 0; wb_id = '0; wb_data = '0; wb_exception_type = EXC_TYPE_NULL;
        commit_en = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [EW-1:0] exc);
        write_en = 1; write_pc = pc; write_exception_type = exc;
        write_reg_write_en = pc[3]; write_reg_write_addr = pc[6:2]; write_is_delayslot = pc[2];
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [EW-1:0] exc);
        idle(); set_alloc(pc, exc); tick(); idle();
    endtask

    task automatic do_wb(input logic [AW-1:0] id, input logic [31:0] d, input logic [EW-1:0] exc);
        idle(); wb_en = 1; wb_id = id; wb_data = d; wb_exception_type = exc; tick(); idle();
    endtask

    task automatic do_commit();
        idle(); commit_en = 1; tick(); idle();
    endtask

    task automatic do_flush();
        idle(); flush = 1; tick(); idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        idle();
        rst = 1;
        #12;
        tick();
        rst = 0;
        tick();

        // Reset values.
        check("rst_count",      64'(count),                 64'd0);
        check("rst_can_write",  64'(can_write),             64'd1);
        check("rst_write_addr", 64'(write_addr),            64'd0);
        check("rst_can_commit", 64'(can_commit),            64'd0);
        check("rst_commit_pc",  64'(commit_pc),             64'd0);

        // Fill all 16 entries, then try a 17th.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_write_addr", 64'(write_addr), 64'(i));
            do_alloc(32'h100 + 32'(4 * i), EXC_TYPE_NULL);
        end
        check("full_count",     64'(count),     64'd16);
        check("full_can_write", 64'(can_write), 64'd0);
        do_alloc(32'h140, EXC_TYPE_NULL);
        check("over_count",      64'(count),      64'd16);
        check("over_write_addr", 64'(write_addr), 64'd0);
        check("over_commit_pc",  64'(commit_pc),  64'h100);
        check("over_can_commit", 64'(can_commit), 64'd0);
        do_flush();
        check("flush1_count", 64'(count), 64'd0);

        // Out-of-order write-back.
        do_alloc(32'h200, EXC_TYPE_NULL);
        do_alloc(32'h204, EXC_TYPE_NULL);
        do_alloc(32'h208, EXC_TYPE_NULL);
        do_wb(2, 32'hA, EXC_TYPE_NULL);
        check("ooo_wait_cc", 64'(can_commit), 64'd0);
        do_wb(0, 32'hC, EXC_TYPE_NULL);
        check("ooo_cc0",   64'(can_commit),            64'd1);
        check("ooo_data0", 64'(commit_reg_write_data), 64'hC);
        do_commit();
        check("ooo_cc1_wait", 64'(can_commit), 64'd0);
        check("ooo_pc1",      64'(commit_pc),  64'h204);
        do_wb(1, 32'hB, EXC_TYPE_NULL);
        check("ooo_data1", 64'(commit_reg_write_data), 64'hB);
        do_commit();
        check("ooo_cc2",   64'(can_commit),            64'd1);
        check("ooo_data2", 64'(commit_reg_write_data), 64'hA);
        do_commit();
        check("ooo_empty", 64'(count), 64'd0);

        // Decode-time exception completes without write-back.
        do_alloc(32'h220, EW'(3));
        check("exc_cc",  64'(can_commit),            64'd1);
        check("exc_val", 64'(commit_exception_type), 64'd3);
        do_commit();

        // Steady state: 8 outstanding, allocate+commit together for 20 cycles.
        for (int i = 0; i < 8; i++) do_alloc(32'h300 + 32'(4 * i), EW'(1));
        check("ss_count", 64'(count), 64'd8);
        for (int k = 0; k < 20; k++) begin
            check("ss_pc", 64'(commit_pc),
                  (k < 8) ? 64'(32'h300 + 32'(4 * k)) : 64'(32'h400 + 32'(4 * (k - 8))));
            check("ss_cnt", 64'(count), 64'd8);
            idle(); set_alloc(32'h400 + 32'(4 * k), EW'(1)); commit_en = 1;
            tick();
        end
        idle();
        check("ss_end_count", 64'(count),      64'd8);
        check("ss_tail_wrap", 64'(write_addr), 64'd0);
        check("ss_end_pc",    64'(commit_pc),  64'h430);
        for (int i = 0; i < 3; i++) do_commit();
        check("pre_flush_count", 64'(count), 64'd5);

        // Flush with concurrent write and write-back.
        idle(); flush = 1; set_alloc(32'h480, EXC_TYPE_NULL);
        wb_en = 1; wb_id = 11; wb_data = 32'h1234;
        tick(); idle();
        check("fl_count",      64'(count),      64'd0);
        check("fl_can_commit", 64'(can_commit), 64'd0);
        check("fl_write_addr", 64'(write_addr), 64'd0);
        do_wb(11, 32'hDEAD, EW'(2));
        check("fl_old_wb_count", 64'(count),      64'd0);
        check("fl_old_wb_cc",    64'(can_commit), 64'd0);
        do_alloc(32'h500, EXC_TYPE_NULL);
        check("fl_new_cc",   64'(can_commit),            64'd0);
        check("fl_new_pc",   64'(commit_pc),             64'h500);
        check("fl_new_data", 64'(commit_reg_write_data), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle();
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                set_alloc($urandom, ($urandom_range(0, 7) == 0) ? EW'($urandom_range(1, 15)) : EXC_TYPE_NULL);
            if ($urandom_range(0, 1) == 1) begin
                wb_en = 1;
                if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_id = AW'(m_q[$urandom_range(0, m_q.size() - 1)]);
                else
                    wb_id = AW'($urandom_range(0, DEPTH - 1));
                wb_data = $urandom;
                wb_exception_type = ($urandom_range(0, 7) == 0) ? EW'($urandom_range(1, 15)) : EXC_TYPE_NULL;
            end
            commit_en = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle();

        // Asynchronous reset mid-cycle with entries pending.
        do_flush();
        do_alloc(32'h600, EW'(5));
        do_alloc(32'h604, EXC_TYPE_NULL);
        do_alloc(32'h608, EXC_TYPE_NULL);
        check("ar_pre_count", 64'(count), 64'd3);
        #2 rst = 1;
        #1;
        check("ar_count",      64'(count),                 64'd0);
        check("ar_can_write",  64'(can_write),             64'd1);
        check("ar_write_addr", 64'(write_addr),            64'd0);
        check("ar_can_commit", 64'(can_commit),            64'd0);
        check("ar_commit_pc",  64'(commit_pc),             64'd0);
        check("ar_commit_exc", 64'(commit_exception_type), 64'd0);
        tick();
        rst = 0;
        do_alloc(32'h700, EXC_TYPE_NULL);
        check("post_ar_count", 64'(count),     64'd1);
        check("post_ar_pc",    64'(commit_pc), 64'h700);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
